// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU port C, debug/loader port D) in front of a single
// fixed-latency data memory; sequences issue, latency wait and read capture.
module dmem_arbiter #(
    parameter int LATENCY     = 1,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [63:0] c_addr,
    input  logic [63:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [63:0] c_rdata,
    output logic        cpu_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata
);

    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_CAPT  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_last_d;
    logic               r_sel_d;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_m_en;
    logic               r_m_we;
    logic [63:0]        r_m_addr;
    logic [63:0]        r_m_wdata;
    logic               r_c_gnt;
    logic               r_d_gnt;
    logic               r_c_rvalid;
    logic               r_d_rvalid;
    logic [63:0]        r_c_rdata;
    logic [63:0]        r_d_rdata;

    logic               w_c_elig;
    logic               w_d_elig;
    logic               w_pick_d;
    logic               w_win_we;
    logic [63:0]        w_win_addr;
    logic [63:0]        w_win_wdata;

    // A port in its rvalid cycle still shows the old request, so it sits out.
    assign w_c_elig = c_req & ~r_c_rvalid;
    assign w_d_elig = d_req & ~r_d_rvalid;

    // Winner selection for the current IDLE cycle.
    always_comb begin
        if (w_c_elig && w_d_elig) begin
            w_pick_d = (ROUND_ROBIN != 1'b0) ? ~r_last_d : 1'b0;
        end else begin
            w_pick_d = w_d_elig;
        end
    end

    assign w_win_we    = w_pick_d ? d_we    : c_we;
    assign w_win_addr  = w_pick_d ? d_addr  : c_addr;
    assign w_win_wdata = w_pick_d ? d_wdata : c_wdata;

    // Access sequencer: arbitration, issue, latency wait and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last_d   <= 1'b1;
            r_sel_d    <= 1'b0;
            r_cnt      <= '0;
            r_m_en     <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= 64'd0;
            r_m_wdata  <= 64'd0;
            r_c_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_rdata  <= 64'd0;
            r_d_rdata  <= 64'd0;
        end else begin
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_c_elig || w_d_elig) begin
                        r_m_en    <= 1'b1;
                        r_m_we    <= w_win_we;
                        r_m_addr  <= w_win_addr;
                        r_m_wdata <= w_win_wdata;
                        r_c_gnt   <= ~w_pick_d;
                        r_d_gnt   <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        r_sel_d   <= w_pick_d;
                        r_state   <= S_ISSUE;
                    end else begin
                        r_m_en    <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_m_en  <= 1'b0;
                    r_m_we  <= 1'b0;
                    r_c_gnt <= 1'b0;
                    r_d_gnt <= 1'b0;
                    if (r_m_we) begin
                        r_state <= S_IDLE;
                    end else if (LATENCY == 1) begin
                        r_state <= S_CAPT;
                    end else begin
                        r_cnt   <= CNT_W'(LATENCY - 2);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_CAPT;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                S_CAPT: begin
                    if (r_sel_d) begin
                        r_d_rdata  <= m_rdata;
                        r_d_rvalid <= 1'b1;
                    end else begin
                        r_c_rdata  <= m_rdata;
                        r_c_rvalid <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign c_gnt    = r_c_gnt;
    assign d_gnt    = r_d_gnt;
    assign c_rvalid = r_c_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign c_rdata  = r_c_rdata;
    assign d_rdata  = r_d_rdata;
    assign m_en     = r_m_en;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;

    // A granted CPU write completes in its grant cycle; reads stall until rvalid.
    assign cpu_stall = c_req & ~(r_c_gnt & r_m_we) & ~r_c_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (LAT1/RR, LAT1/fixed,
// LAT3/RR) share stimulus; each scenario checks the relevant instance.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [63:0] c_addr, c_wdata, d_addr, d_wdata;

    logic        c_gnt_a    [3];
    logic        c_rvalid_a [3];
    logic [63:0] c_rdata_a  [3];
    logic        stall_a    [3];
    logic        d_gnt_a    [3];
    logic        d_rvalid_a [3];
    logic [63:0] d_rdata_a  [3];
    logic        m_en_a     [3];
    logic        m_we_a     [3];
    logic [63:0] m_addr_a   [3];
    logic [63:0] m_wdata_a  [3];
    logic [63:0] m_rdata_a  [3];

    int n_checks = 0;
    int n_fails  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        // Memory model: read data derived from the held address.
        assign m_rdata_a[g] = {32'hDEAD_BEEF, m_addr_a[g][35:4]};

        dmem_arbiter #(
            .LATENCY     ((g == 2) ? 3 : 1),
            .ROUND_ROBIN ((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .c_req     (c_req),
            .c_we      (c_we),
            .c_addr    (c_addr),
            .c_wdata   (c_wdata),
            .c_gnt     (c_gnt_a[g]),
            .c_rvalid  (c_rvalid_a[g]),
            .c_rdata   (c_rdata_a[g]),
            .cpu_stall (stall_a[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt_a[g]),
            .d_rvalid  (d_rvalid_a[g]),
            .d_rdata   (d_rdata_a[g]),
            .m_en      (m_en_a[g]),
            .m_we      (m_we_a[g]),
            .m_addr    (m_addr_a[g]),
            .m_wdata   (m_wdata_a[g]),
            .m_rdata   (m_rdata_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        c_req = 1'b0; c_we = 1'b0; c_addr = 64'd0; c_wdata = 64'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 64'd0; d_wdata = 64'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        do_reset();

        // Reset state
        check_val("rst_m_en",   64'(m_en_a[0]),    64'd0);
        check_val("rst_c_gnt",  64'(c_gnt_a[0]),   64'd0);
        check_val("rst_rvalid", 64'(c_rvalid_a[0]), 64'd0);
        check_val("rst_rdata",  c_rdata_a[0],      64'd0);
        check_val("rst_stall",  64'(stall_a[0]),   64'd0);

        // 1: C read at 0x10, LATENCY=1
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h10;
        #1;
        check_val("t1_stall_T", 64'(stall_a[0]), 64'd1);
        check_val("t1_gnt_T",   64'(c_gnt_a[0]), 64'd0);
        tick();
        check_val("t1_gnt",     64'(c_gnt_a[0]), 64'd1);
        check_val("t1_m_en",    64'(m_en_a[0]),  64'd1);
        check_val("t1_m_addr",  m_addr_a[0],     64'h10);
        check_val("t1_m_we",    64'(m_we_a[0]),  64'd0);
        check_val("t1_stall1",  64'(stall_a[0]), 64'd1);
        tick();
        check_val("t1_gnt2",    64'(c_gnt_a[0]), 64'd0);
        check_val("t1_m_en2",   64'(m_en_a[0]),  64'd0);
        check_val("t1_stall2",  64'(stall_a[0]), 64'd1);
        check_val("t1_rv2",     64'(c_rvalid_a[0]), 64'd0);
        tick();
        check_val("t1_rvalid",  64'(c_rvalid_a[0]), 64'd1);
        check_val("t1_rdata",   c_rdata_a[0],    64'hDEAD_BEEF_0000_0001);
        check_val("t1_stall3",  64'(stall_a[0]), 64'd0);
        check_val("t1_d_rv",    64'(d_rvalid_a[0]), 64'd0);
        c_req = 1'b0;
        tick();
        check_val("t1_rv_pulse", 64'(c_rvalid_a[0]), 64'd0);
        check_val("t1_rdata_hold", c_rdata_a[0],  64'hDEAD_BEEF_0000_0001);

        // 2: C write 0x20 <- 0x1234
        c_req = 1'b1; c_we = 1'b1; c_addr = 64'h20; c_wdata = 64'h1234;
        #1;
        check_val("t2_stall_T", 64'(stall_a[0]), 64'd1);
        tick();
        check_val("t2_gnt",     64'(c_gnt_a[0]), 64'd1);
        check_val("t2_m_en",    64'(m_en_a[0]),  64'd1);
        check_val("t2_m_we",    64'(m_we_a[0]),  64'd1);
        check_val("t2_m_wdata", m_wdata_a[0],    64'h1234);
        check_val("t2_m_addr",  m_addr_a[0],     64'h20);
        check_val("t2_stall",   64'(stall_a[0]), 64'd0);
        c_req = 1'b0;
        tick();
        check_val("t2_m_we_off", 64'(m_we_a[0]), 64'd0);
        check_val("t2_m_addr_hold", m_addr_a[0], 64'h20);
        for (int k = 0; k < 3; k++) begin
            check_val("t2_no_rvalid", 64'(c_rvalid_a[0]), 64'd0);
            tick();
        end

        // 3: continuous read contention, round robin (instance 0)
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200;
        for (int k = 1; k <= 12; k++) begin
            logic is_gnt, is_rv, own_d;
            tick();
            is_gnt = ((k % 3) == 1);
            is_rv  = ((k % 3) == 0);
            own_d  = is_rv ? (((k / 3) - 1) % 2 == 1) : (((k - 1) / 3) % 2 == 1);
            check_val("t3_c_gnt",    64'(c_gnt_a[0]),    64'(is_gnt & ~own_d));
            check_val("t3_d_gnt",    64'(d_gnt_a[0]),    64'(is_gnt & own_d));
            check_val("t3_c_rvalid", 64'(c_rvalid_a[0]), 64'(is_rv & ~own_d));
            check_val("t3_d_rvalid", 64'(d_rvalid_a[0]), 64'(is_rv & own_d));
            if (is_rv && !own_d) check_val("t3_c_rdata", c_rdata_a[0], 64'hDEAD_BEEF_0000_0010);
            if (is_rv && own_d)  check_val("t3_d_rdata", d_rdata_a[0], 64'hDEAD_BEEF_0000_0020);
        end

        // 4: fixed priority (instance 1): C writes continuously, D starves
        do_reset();
        c_req = 1'b1; c_we = 1'b1; c_addr = 64'h300; c_wdata = 64'h55;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h400;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_val("t4_c_gnt", 64'(c_gnt_a[1]), 64'((k % 2) == 1));
            check_val("t4_d_gnt", 64'(d_gnt_a[1]), 64'd0);
        end
        c_req = 1'b0;
        tick();
        check_val("t4_d_gnt_idle", 64'(d_gnt_a[1]), 64'd0);
        tick();
        check_val("t4_d_gnt",   64'(d_gnt_a[1]), 64'd1);
        check_val("t4_m_addr",  m_addr_a[1],     64'h400);
        check_val("t4_m_we",    64'(m_we_a[1]),  64'd0);

        // 5: LATENCY=3 D read at 0x40 (instance 2), C joins at T+2
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
        tick();
        check_val("t5_d_gnt",  64'(d_gnt_a[2]), 64'd1);
        check_val("t5_m_en",   64'(m_en_a[2]),  64'd1);
        tick();
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h80;
        #1;
        check_val("t5_m_en2",  64'(m_en_a[2]),  64'd0);
        check_val("t5_stall",  64'(stall_a[2]), 64'd1);
        for (int k = 3; k <= 4; k++) begin
            tick();
            check_val("t5_wait_c_gnt", 64'(c_gnt_a[2]),    64'd0);
            check_val("t5_wait_d_rv",  64'(d_rvalid_a[2]), 64'd0);
        end
        tick();
        check_val("t5_d_rvalid", 64'(d_rvalid_a[2]), 64'd1);
        check_val("t5_d_rdata",  d_rdata_a[2],       64'hDEAD_BEEF_0000_0004);
        check_val("t5_c_gnt5",   64'(c_gnt_a[2]),    64'd0);
        d_req = 1'b0;
        tick();
        check_val("t5_c_gnt6",   64'(c_gnt_a[2]),    64'd1);
        check_val("t5_m_addr6",  m_addr_a[2],        64'h80);

        // 6: reset during WAIT of a C read (instance 2)
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h70;
        tick();
        check_val("t6_gnt", 64'(c_gnt_a[2]), 64'd1);
        tick();
        rst = 1'b1; c_req = 1'b0;
        tick();
        rst = 1'b0;
        check_val("t6_m_en",    64'(m_en_a[2]),     64'd0);
        check_val("t6_m_we",    64'(m_we_a[2]),     64'd0);
        check_val("t6_m_addr",  m_addr_a[2],        64'd0);
        check_val("t6_c_gnt",   64'(c_gnt_a[2]),    64'd0);
        check_val("t6_c_rv",    64'(c_rvalid_a[2]), 64'd0);
        check_val("t6_c_rdata", c_rdata_a[2],       64'd0);
        check_val("t6_stall",   64'(stall_a[2]),    64'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_val("t6_no_rvalid", 64'(c_rvalid_a[2]), 64'd0);
        end
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h30;
        tick();
        check_val("t6_new_gnt", 64'(c_gnt_a[2]), 64'd1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check_val("t6_new_rv_early", 64'(c_rvalid_a[2]), 64'd0);
        end
        tick();
        check_val("t6_new_rvalid", 64'(c_rvalid_a[2]), 64'd1);
        check_val("t6_new_rdata",  c_rdata_a[2],       64'hDEAD_BEEF_0000_0003);
        c_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
